// File: rtl/lzc_norm_pipe_if.sv
// lzc_norm_pipe_if: valid/ready bundle for the normaliser.
// Upstream side: in_valid, in_ready, in_sig, in_exp.
// Downstream side: out_valid, out_ready, out_sig, out_exp, out_lzc, out_zero, out_uflow.
// The master modport drives beats in and accepts results; the slave modport is the normaliser.
interface lzc_norm_pipe_if #(
    parameter int WIDTH = 28,
    parameter int EXP_W = 8
);
    localparam int CW = $clog2(WIDTH + 1);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sig;
    logic [EXP_W-1:0] in_exp;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sig;
    logic [EXP_W-1:0] out_exp;
    logic [CW-1:0]    out_lzc;
    logic             out_zero;
    logic             out_uflow;
    modport master (
        output in_valid, in_sig, in_exp, out_ready,
        input  in_ready, out_valid, out_sig, out_exp, out_lzc, out_zero, out_uflow
    );
    modport slave (
        input  in_valid, in_sig, in_exp, out_ready,
        output in_ready, out_valid, out_sig, out_exp, out_lzc, out_zero, out_uflow
    );
endinterface

// File: rtl/lzc_norm_pipe.sv
// lzc_norm_pipe: two-stage pipelined leading-zero count and normalise with exponent clamp.
// Ports: clk, rst_n (async active-low), flush (sync clear of both stages),
// bus (slave side of lzc_norm_pipe_if: input beat in, normalised result out).
module lzc_norm_pipe #(
    parameter int WIDTH = 28,
    parameter int EXP_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    lzc_norm_pipe_if.slave       bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int L  = $clog2(WIDTH);
    localparam int P  = 1 << L;
    localparam int XW = CW + EXP_W;

    // Valid/position tree over the LSB-zero-padded input, combined in place level by level.
    function automatic logic [CW-1:0] lzc_f(input logic [WIDTH-1:0] s);
        logic [P-1:0]        v;
        logic [P-1:0][L-1:0] p;
        logic [L-1:0]        pn;
        v = '0;
        v[P-1 -: WIDTH] = s;
        p = '0;
        for (int k = 1; k <= L; k++) begin
            for (int n = 0; n < (P >> k); n++) begin
                pn   = v[2*n+1] ? p[2*n+1] : p[2*n] + L'(1 << (k - 1));
                v[n] = v[2*n+1] | v[2*n];
                p[n] = pn;
            end
        end
        return v[0] ? CW'(p[0]) : CW'(WIDTH);
    endfunction

    logic             s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [WIDTH-1:0] s1_sig_q, s1_sig_d, s2_sig_q, s2_sig_d;
    logic [EXP_W-1:0] s1_exp_q, s1_exp_d, s2_exp_q, s2_exp_d;
    logic [CW-1:0]    s1_lzc_q, s1_lzc_d, s2_lzc_q, s2_lzc_d;
    logic             s1_zero_q, s1_zero_d, s2_zero_q, s2_zero_d;
    logic             s2_uflow_q, s2_uflow_d;
    logic             s1_load, s2_load, in_fire, mv, norm;
    logic [CW-1:0]    shift;
    logic [WIDTH-1:0] sh;
    logic [EXP_W-1:0] exp_n;
    logic             uflow_n;

    assign s2_load      = !s2_v_q || bus.out_ready;
    assign s1_load      = !s1_v_q || s2_load;
    assign bus.in_ready = s1_load && !flush;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign mv           = s2_load && s1_v_q;

    always_comb begin
        s1_v_d    = flush ? 1'b0 : s1_load ? in_fire : s1_v_q;
        s1_sig_d  = in_fire ? bus.in_sig : s1_sig_q;
        s1_exp_d  = in_fire ? bus.in_exp : s1_exp_q;
        s1_lzc_d  = in_fire ? lzc_f(bus.in_sig) : s1_lzc_q;
        s1_zero_d = in_fire ? (bus.in_sig == '0) : s1_zero_q;
    end

    // lzc < exp keeps the exponent positive; otherwise shift only down to exponent 1 and go denormal.
    always_comb begin
        norm    = XW'(s1_lzc_q) < XW'(s1_exp_q);
        shift   = s1_zero_q ? '0 : norm ? s1_lzc_q : (s1_exp_q != '0) ? CW'(s1_exp_q - 1'b1) : '0;
        exp_n   = (!s1_zero_q && norm) ? s1_exp_q - EXP_W'(s1_lzc_q) : '0;
        uflow_n = !s1_zero_q && !norm && (s1_exp_q != '0 || !s1_sig_q[WIDTH-1]);
        sh      = s1_sig_q;
        for (int i = 0; i < CW; i++) sh = shift[i] ? sh << (1 << i) : sh;
    end

    always_comb begin
        s2_v_d     = flush ? 1'b0 : s2_load ? s1_v_q : s2_v_q;
        s2_sig_d   = mv ? sh : s2_sig_q;
        s2_exp_d   = mv ? exp_n : s2_exp_q;
        s2_lzc_d   = mv ? s1_lzc_q : s2_lzc_q;
        s2_zero_d  = mv ? s1_zero_q : s2_zero_q;
        s2_uflow_d = mv ? uflow_n : s2_uflow_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q     <= 1'b0;
            s1_sig_q   <= '0;
            s1_exp_q   <= '0;
            s1_lzc_q   <= '0;
            s1_zero_q  <= 1'b0;
            s2_v_q     <= 1'b0;
            s2_sig_q   <= '0;
            s2_exp_q   <= '0;
            s2_lzc_q   <= '0;
            s2_zero_q  <= 1'b0;
            s2_uflow_q <= 1'b0;
        end else begin
            s1_v_q     <= s1_v_d;
            s1_sig_q   <= s1_sig_d;
            s1_exp_q   <= s1_exp_d;
            s1_lzc_q   <= s1_lzc_d;
            s1_zero_q  <= s1_zero_d;
            s2_v_q     <= s2_v_d;
            s2_sig_q   <= s2_sig_d;
            s2_exp_q   <= s2_exp_d;
            s2_lzc_q   <= s2_lzc_d;
            s2_zero_q  <= s2_zero_d;
            s2_uflow_q <= s2_uflow_d;
        end
    end

    assign bus.out_valid = s2_v_q;
    assign bus.out_sig   = s2_sig_q;
    assign bus.out_exp   = s2_exp_q;
    assign bus.out_lzc   = s2_lzc_q;
    assign bus.out_zero  = s2_zero_q;
    assign bus.out_uflow = s2_uflow_q;
endmodule
